// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I register writeback slice.
// Holds the architectural register-file widths, the x0 address constant and
// the {addr, data} write-request layout used by the load-response queue.
package rv32i_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] REG_X0 = '0;

  // Field order matches the {addr, data} packing of the load queue entries.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rv32i_wb_fifo.sv
// Generic synchronous FIFO with asynchronous active-high reset.
// Ports:
//   clk, rst     clock / async reset (reset empties the FIFO)
//   push, din    write strobe and data (ignored while full)
//   pop, dout    read strobe and head-of-queue data (ignored while empty)
//   full, empty  occupancy flags
// DEPTH must be a power of two and at least 1.
module rv32i_wb_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Storage needs no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/rv32i_reg_wb_arbiter.sv
// Register-file write-port arbiter with pending-load scoreboard.
// Ports:
//   clk, rst                         clock / async active-high reset
//   wb_valid/wb_addr/wb_data         ALU/CSR writeback, always accepted, top priority
//   ld_issue_valid/addr, ld_issue_ready   load issue; ready while outstanding < MAX_OUT
//   ld_rsp_valid/addr/data, ld_rsp_ready  in-order load responses into the queue
//   rs1_addr, rs2_addr, hazard_stall      decode RAW check against pending loads
//   busy_mask                        bit n set while a load to xn is pending
//   rf_rd_addr/rf_rd_data/rf_rd_we   registered register-file write port
module rv32i_reg_wb_arbiter #(
  parameter int unsigned DATA_W   = rv32i_pkg::DATA_W,
  parameter int unsigned ADDR_W   = rv32i_pkg::ADDR_W,
  parameter int unsigned LQ_DEPTH = 2,
  parameter int unsigned MAX_OUT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_valid,
  input  logic [ADDR_W-1:0]    wb_addr,
  input  logic [DATA_W-1:0]    wb_data,
  input  logic                 ld_issue_valid,
  input  logic [ADDR_W-1:0]    ld_issue_addr,
  output logic                 ld_issue_ready,
  input  logic                 ld_rsp_valid,
  input  logic [ADDR_W-1:0]    ld_rsp_addr,
  input  logic [DATA_W-1:0]    ld_rsp_data,
  output logic                 ld_rsp_ready,
  input  logic [ADDR_W-1:0]    rs1_addr,
  input  logic [ADDR_W-1:0]    rs2_addr,
  output logic                 hazard_stall,
  output logic [2**ADDR_W-1:0] busy_mask,
  output logic [ADDR_W-1:0]    rf_rd_addr,
  output logic [DATA_W-1:0]    rf_rd_data,
  output logic                 rf_rd_we
);

  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
  localparam logic [ADDR_W-1:0] X0 = ADDR_W'(rv32i_pkg::REG_X0);

  logic [ADDR_W+DATA_W-1:0] head;
  logic [ADDR_W-1:0]        head_addr;
  logic [DATA_W-1:0]        head_data;
  logic                     lq_full;
  logic                     lq_empty;
  logic                     lq_push;
  logic                     lq_pop;
  logic                     issue_acc;
  logic [OUT_W-1:0]         out_cnt;
  logic [2**ADDR_W-1:0]     busy_q;
  logic [2**ADDR_W-1:0]     busy_nxt;

  assign ld_rsp_ready   = !lq_full;
  assign ld_issue_ready = (out_cnt < OUT_W'(MAX_OUT));
  assign lq_push        = ld_rsp_valid && !lq_full;
  // Head commits only in cycles the ALU writeback leaves the port free.
  assign lq_pop         = !lq_empty && !wb_valid;
  assign issue_acc      = ld_issue_valid && ld_issue_ready;
  assign head_addr      = head[DATA_W +: ADDR_W];
  assign head_data      = head[DATA_W-1:0];
  assign busy_mask      = busy_q;

  assign hazard_stall = ((rs1_addr != X0) && busy_q[rs1_addr]) ||
                        ((rs2_addr != X0) && busy_q[rs2_addr]);

  rv32i_wb_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (LQ_DEPTH)
  ) u_load_q (
    .clk   (clk),
    .rst   (rst),
    .push  (lq_push),
    .din   ({ld_rsp_addr, ld_rsp_data}),
    .pop   (lq_pop),
    .dout  (head),
    .full  (lq_full),
    .empty (lq_empty)
  );

  // Clear first, then set, so an issue to the committing register keeps its bit.
  always_comb begin
    busy_nxt = busy_q;
    if (lq_pop) busy_nxt[head_addr] = 1'b0;
    if (issue_acc && (ld_issue_addr != X0)) busy_nxt[ld_issue_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt <= '0;
      busy_q  <= '0;
    end else begin
      out_cnt <= out_cnt + OUT_W'(issue_acc) - OUT_W'(lq_pop);
      busy_q  <= busy_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_rd_we   <= 1'b0;
      rf_rd_addr <= '0;
      rf_rd_data <= '0;
    end else if (wb_valid) begin
      rf_rd_we   <= (wb_addr != X0);
      rf_rd_addr <= wb_addr;
      rf_rd_data <= wb_data;
    end else if (lq_pop) begin
      rf_rd_we   <= (head_addr != X0);
      rf_rd_addr <= head_addr;
      rf_rd_data <= head_data;
    end else begin
      rf_rd_we   <= 1'b0;
    end
  end

endmodule
